// File: rtl/seq_sched_pkg.sv
// Shared encoding for the "1011" Mealy detector family.
// Contents: ST_W (state width) and the four per-channel state codes.
// The standalone detectors and their benches use the same encoding.
package seq_sched_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] S_IDLE = 2'd0;
    localparam logic [ST_W-1:0] S_1    = 2'd1;
    localparam logic [ST_W-1:0] S_10   = 2'd2;
    localparam logic [ST_W-1:0] S_101  = 2'd3;

endpackage

// File: rtl/seq1011_step.sv
// Single step of the "1011" Mealy detector, purely combinational.
// The scheduler instantiates this once and feeds it from its state file.
//
// state  | meaning
// -------+---------------------------------
// S_IDLE | nothing useful seen
// S_1    | seen "1"
// S_10   | seen "10"
// S_101  | seen "101"; a 1 now completes a match
//
// Parameters: OVERLAP - 1: after a match resume in S_1, 0: resume in S_IDLE
// Ports:
//   st     in  ST_W  current state of the channel being stepped
//   x      in  1     incoming bit
//   st_nxt out ST_W  state after consuming x
//   match  out 1     x completed "1011"
module seq1011_step
    import seq_sched_pkg::*;
#(
    parameter int OVERLAP = 1
) (
    input  logic [ST_W-1:0] st,
    input  logic            x,
    output logic [ST_W-1:0] st_nxt,
    output logic            match
);

    always_comb begin
        st_nxt = S_IDLE;
        match  = 1'b0;
        case (st)
            S_IDLE: st_nxt = x ? S_1   : S_IDLE;
            S_1:    st_nxt = x ? S_1   : S_10;
            S_10:   st_nxt = x ? S_101 : S_IDLE;
            S_101: begin
                if (x) begin
                    match  = 1'b1;
                    // trailing "1" of the match is also a valid prefix
                    st_nxt = (OVERLAP != 0) ? S_1 : S_IDLE;
                end else begin
                    st_nxt = S_10;
                end
            end
            default: st_nxt = S_IDLE;
        endcase
    end

endmodule

// File: rtl/seq1011_chan_sched.sv
// Round-robin scheduler sharing one "1011" detector among NCH serial channels.
// Each cycle at most one eligible channel is granted; its stored state is
// stepped with its bit and any match is reported one cycle later, tagged
// with the channel index.
//
// Optional feature macro: SEQ_SCHED_CNT_EN (per-channel saturating match
// counters readable through cnt_sel/cnt_rdata; tied to 0 when undefined).
//
// Ports:
//   clk        in  1      system clock, rising edge
//   reset      in  1      synchronous, active-high
//   in_valid   in  NCH    channel has a bit pending
//   in_bit     in  NCH    serial bit per channel
//   in_ready   out NCH    one-hot grant (combinational)
//   chan_clr   in  NCH    per-channel clear; masks the channel this cycle
//   z_valid    out 1      registered match pulse
//   z_ch       out CH_W   channel of the last match (held)
//   cnt_sel    in  CH_W   counter readout select (must be < NCH)
//   cnt_rdata  out CNT_W  match count of channel cnt_sel
module seq1011_chan_sched
    import seq_sched_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int CH_W    = 2,
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH-1:0]   in_bit,
    output logic [NCH-1:0]   in_ready,
    input  logic [NCH-1:0]   chan_clr,
    output logic             z_valid,
    output logic [CH_W-1:0]  z_ch,
    input  logic [CH_W-1:0]  cnt_sel,
    output logic [CNT_W-1:0] cnt_rdata
);

    logic [ST_W-1:0] st_q [NCH];
    logic [ST_W-1:0] st_d [NCH];
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            z_valid_q, z_valid_d;
    logic [CH_W-1:0] z_ch_q, z_ch_d;

    logic [NCH-1:0]  eligible;
    logic            grant_found;
    logic [CH_W-1:0] grant_idx;
    logic [ST_W-1:0] step_st_nxt;
    logic            step_match;
    logic            hit;

    assign eligible = in_valid & ~chan_clr;

    // Scan rr_ptr, rr_ptr+1, ... wrapping at NCH; first eligible wins.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        in_ready    = '0;
        idx         = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(idx);
            end
        end
        if (grant_found) in_ready[grant_idx] = 1'b1;
    end

    seq1011_step #(
        .OVERLAP (OVERLAP)
    ) u_step (
        .st     (st_q[grant_idx]),
        .x      (in_bit[grant_idx]),
        .st_nxt (step_st_nxt),
        .match  (step_match)
    );

    assign hit = grant_found & step_match;

    // The granted channel is never cleared in the same cycle (clear masks it),
    // so the clear and step updates cannot collide.
    always_comb begin
        st_d = st_q;
        for (int i = 0; i < NCH; i++) begin
            if (chan_clr[i]) st_d[i] = S_IDLE;
        end
        if (grant_found) st_d[grant_idx] = step_st_nxt;

        rr_ptr_d = rr_ptr_q;
        if (grant_found) begin
            rr_ptr_d = (grant_idx == CH_W'(NCH - 1)) ? '0 : grant_idx + 1'b1;
        end

        z_valid_d = hit;
        z_ch_d    = hit ? grant_idx : z_ch_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q      <= '{default: S_IDLE};
            rr_ptr_q  <= '0;
            z_valid_q <= 1'b0;
            z_ch_q    <= '0;
        end else begin
            st_q      <= st_d;
            rr_ptr_q  <= rr_ptr_d;
            z_valid_q <= z_valid_d;
            z_ch_q    <= z_ch_d;
        end
    end

    assign z_valid = z_valid_q;
    assign z_ch    = z_ch_q;

`ifdef SEQ_SCHED_CNT_EN
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NCH; i++) begin
            if (chan_clr[i]) cnt_d[i] = '0;
        end
        if (hit && (cnt_q[grant_idx] != '1)) begin
            cnt_d[grant_idx] = cnt_q[grant_idx] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_rdata = cnt_q[cnt_sel];
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^cnt_sel;
    assign cnt_rdata      = '0;
`endif

endmodule

// File: tb/tb_seq1011_chan_sched.sv
// Bench for seq1011_chan_sched: instance A (OVERLAP=1, CNT_W=8) and
// instance B (OVERLAP=0, CNT_W=2) share all inputs and are checked against a
// history-based reference model every cycle.
module tb_seq1011_chan_sched;

    localparam int NCH  = 4;
    localparam int CH_W = 2;

    logic            clk;
    logic            reset;
    logic [NCH-1:0]  in_valid, in_bit, chan_clr;
    logic [CH_W-1:0] cnt_sel;
    logic [NCH-1:0]  in_ready_a, in_ready_b;
    logic            z_valid_a, z_valid_b;
    logic [CH_W-1:0] z_ch_a, z_ch_b;
    logic [7:0]      cnt_rdata_a;
    logic [1:0]      cnt_rdata_b;

    seq1011_chan_sched #(.NCH(NCH), .CH_W(CH_W), .OVERLAP(1), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready_a), .chan_clr(chan_clr), .z_valid(z_valid_a),
        .z_ch(z_ch_a), .cnt_sel(cnt_sel), .cnt_rdata(cnt_rdata_a)
    );

    seq1011_chan_sched #(.NCH(NCH), .CH_W(CH_W), .OVERLAP(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready_b), .chan_clr(chan_clr), .z_valid(z_valid_b),
        .z_ch(z_ch_b), .cnt_sel(cnt_sel), .cnt_rdata(cnt_rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: per channel the last four consumed bits and how many
    // bits count toward a match (reset to 0 after a match when non-overlapping).
    logic [3:0] m_hist [2][NCH];
    int         m_len  [2][NCH];
    int         m_cnt  [2][NCH];
    logic       m_zv   [2];
    int         m_zch  [2];
    int         m_ptr;
    int         cnt_max [2] = '{255, 3};
    logic [NCH-1:0] last_ready_a;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear_all();
        m_ptr = 0;
        for (int n = 0; n < 2; n++) begin
            m_zv[n]  = 1'b0;
            m_zch[n] = 0;
            for (int i = 0; i < NCH; i++) begin
                m_hist[n][i] = '0; m_len[n][i] = 0; m_cnt[n][i] = 0;
            end
        end
    endtask

    // Called just after a posedge; returns just after the next posedge.
    task automatic run_cycle(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                             input logic [NCH-1:0] c, input logic r,
                             input logic [CH_W-1:0] sel);
        int g;
        int exp_cnt;
        in_valid = v; in_bit = b; chan_clr = c; reset = r; cnt_sel = sel;
        #4;
        g = -1;
        for (int k = 0; k < NCH; k++) begin
            int idx;
            idx = (m_ptr + k) % NCH;
            if (g < 0 && v[idx] && !c[idx]) g = idx;
        end
        last_ready_a = in_ready_a;
        check("in_ready_a", int'(in_ready_a), (g >= 0) ? (1 << g) : 0);
        check("in_ready_b", int'(in_ready_b), (g >= 0) ? (1 << g) : 0);
        @(posedge clk);
        #1;
        if (r) begin
            model_clear_all();
        end else begin
            for (int n = 0; n < 2; n++) begin
                m_zv[n] = 1'b0;
                for (int i = 0; i < NCH; i++) begin
                    if (c[i]) begin
                        m_hist[n][i] = '0; m_len[n][i] = 0; m_cnt[n][i] = 0;
                    end
                end
                if (g >= 0) begin
                    m_hist[n][g] = {m_hist[n][g][2:0], b[g]};
                    if (m_len[n][g] < 4) m_len[n][g]++;
                    if (m_len[n][g] >= 4 && m_hist[n][g] == 4'b1011) begin
                        m_zv[n]  = 1'b1;
                        m_zch[n] = g;
                        if (m_cnt[n][g] < cnt_max[n]) m_cnt[n][g]++;
                        if (n == 1) m_len[n][g] = 0;
                    end
                end
            end
            if (g >= 0) m_ptr = (g + 1) % NCH;
        end
        check("z_valid_a", int'(z_valid_a), int'(m_zv[0]));
        check("z_valid_b", int'(z_valid_b), int'(m_zv[1]));
        check("z_ch_a", int'(z_ch_a), m_zch[0]);
        check("z_ch_b", int'(z_ch_b), m_zch[1]);
`ifdef SEQ_SCHED_CNT_EN
        exp_cnt = m_cnt[0][sel];
        check("cnt_a", int'(cnt_rdata_a), exp_cnt);
        exp_cnt = m_cnt[1][sel];
        check("cnt_b", int'(cnt_rdata_b), exp_cnt);
`else
        exp_cnt = 0;
        check("cnt_a", int'(cnt_rdata_a), exp_cnt);
        check("cnt_b", int'(cnt_rdata_b), exp_cnt);
`endif
    endtask

    task automatic feed(input int ch, input logic x, input logic [CH_W-1:0] sel);
        logic [NCH-1:0] v;
        v = '0;
        v[ch] = 1'b1;
        run_cycle(v, x ? v : '0, '0, 1'b0, sel);
    endtask

    task automatic do_reset(input logic [CH_W-1:0] sel);
        run_cycle('0, '0, '0, 1'b1, sel);
    endtask

    typedef struct {
        logic [NCH-1:0]  v;
        logic [NCH-1:0]  b;
        logic [NCH-1:0]  rdy;
        logic            zv_a;
        logic            zv_b;
        logic [CH_W-1:0] zch;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [3:0] pat;
        int         pulses_ch [$];
        int         grants    [NCH];
        int         exp_sat;

        // ch1 stream 1,0,1,1,0,1,1: overlap matches after bits 4 and 7,
        // non-overlap only after bit 4
        tbl[0] = '{4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b0, 2'd0};
        tbl[1] = '{4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b0, 2'd0};
        tbl[2] = '{4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b0, 2'd0};
        tbl[3] = '{4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1};
        tbl[4] = '{4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b0, 2'd1};
        tbl[5] = '{4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b0, 2'd1};
        tbl[6] = '{4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b0, 2'd1};

        in_valid = '0; in_bit = '0; chan_clr = '0; cnt_sel = '0;
        reset = 1'b1;
        model_clear_all();
        repeat (2) @(posedge clk);
        #1;
        check("rst_z_valid_a", int'(z_valid_a), 0);
        check("rst_z_valid_b", int'(z_valid_b), 0);
        check("rst_z_ch_a", int'(z_ch_a), 0);
        check("rst_cnt_a", int'(cnt_rdata_a), 0);

        // Table-driven single-channel stream
        do_reset(2'd1);
        for (int i = 0; i < 7; i++) begin
            run_cycle(tbl[i].v, tbl[i].b, '0, 1'b0, 2'd1);
            check("tbl_ready", int'(last_ready_a), int'(tbl[i].rdy));
            check("tbl_zv_a", int'(z_valid_a), int'(tbl[i].zv_a));
            check("tbl_zv_b", int'(z_valid_b), int'(tbl[i].zv_b));
            check("tbl_zch", int'(z_ch_a), int'(tbl[i].zch));
        end
`ifdef SEQ_SCHED_CNT_EN
        check("tbl_cnt_a", int'(cnt_rdata_a), 2);
        check("tbl_cnt_b", int'(cnt_rdata_b), 1);
`endif

        // All channels valid: fair rotation, 1011 on ch0 and ch2
        do_reset(2'd0);
        pat = 4'b1011;
        for (int i = 0; i < NCH; i++) grants[i] = 0;
        for (int t = 0; t < 16; t++) begin
            logic [NCH-1:0] b;
            b = '0;
            b[0] = pat[3 - t/4];
            b[2] = pat[3 - t/4];
            run_cycle('1, b, '0, 1'b0, 2'd0);
            for (int i = 0; i < NCH; i++) if (last_ready_a[i]) grants[i]++;
            check("rr_order", int'(last_ready_a), 1 << (t % NCH));
            if (z_valid_a) pulses_ch.push_back(int'(z_ch_a));
        end
        for (int i = 0; i < NCH; i++) check("rr_grants", grants[i], 4);
        check("rr_pulses", pulses_ch.size(), 2);
        if (pulses_ch.size() == 2) begin
            check("rr_pulse0_ch", pulses_ch[0], 0);
            check("rr_pulse1_ch", pulses_ch[1], 2);
        end

        // ch3 cleared while in S_101
        do_reset(2'd3);
        feed(3, 1'b1, 2'd3); feed(3, 1'b0, 2'd3); feed(3, 1'b1, 2'd3);
        run_cycle(4'b1000, 4'b1000, 4'b1000, 1'b0, 2'd3);
        check("clr_ready", int'(last_ready_a), 0);
        feed(3, 1'b1, 2'd3);
        check("clr_no_match_a", int'(z_valid_a), 0);
        check("clr_no_match_b", int'(z_valid_b), 0);
        feed(3, 1'b0, 2'd3); feed(3, 1'b1, 2'd3); feed(3, 1'b1, 2'd3);
        check("clr_s1_match_a", int'(z_valid_a), 1);
        check("clr_s1_match_b", int'(z_valid_b), 1);
        check("clr_s1_ch", int'(z_ch_a), 3);

        // Reset while ch0 sits in S_101 with a completing bit
        do_reset(2'd0);
        feed(0, 1'b1, 2'd0); feed(0, 1'b0, 2'd0); feed(0, 1'b1, 2'd0);
        run_cycle(4'b0001, 4'b0001, '0, 1'b1, 2'd0);
        check("midrst_zv_a", int'(z_valid_a), 0);
        check("midrst_zv_b", int'(z_valid_b), 0);
        feed(0, 1'b0, 2'd0); feed(0, 1'b1, 2'd0); feed(0, 1'b1, 2'd0);
        check("midrst_partial", int'(z_valid_a), 0);
        feed(0, 1'b1, 2'd0); feed(0, 1'b0, 2'd0); feed(0, 1'b1, 2'd0); feed(0, 1'b1, 2'd0);
        check("midrst_full_a", int'(z_valid_a), 1);
        check("midrst_full_ch", int'(z_ch_a), 0);

        // Five matches on ch2: B counter (2 bits) saturates
        do_reset(2'd2);
        for (int m = 0; m < 5; m++) begin
            feed(2, 1'b1, 2'd2); feed(2, 1'b0, 2'd2); feed(2, 1'b1, 2'd2); feed(2, 1'b1, 2'd2);
        end
`ifdef SEQ_SCHED_CNT_EN
        exp_sat = 3;
        check("sat_cnt_a", int'(cnt_rdata_a), 5);
`else
        exp_sat = 0;
`endif
        check("sat_cnt_b", int'(cnt_rdata_b), exp_sat);

        // Randomized traffic against the model
        for (int t = 0; t < 600; t++) begin
            logic [NCH-1:0] v, b, c;
            logic           r;
            v = NCH'($urandom);
            b = NCH'($urandom);
            c = ($urandom_range(0, 11) == 0) ? NCH'($urandom) : '0;
            r = ($urandom_range(0, 79) == 0);
            run_cycle(v, b, c, r, CH_W'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/seq1011_chan_sched.md
Name: seq1011_chan_sched

Overview:
Round-robin scheduler that shares one "1011" Mealy detector datapath among NCH serial bit channels. Per-channel detector state is held in a small state file. Each cycle the block grants at most one valid channel, steps that channel's state with its bit, and reports any match tagged with the channel index. It sits between the serial front-ends and the match-event consumer, replacing NCH separate detector instances.

Parameters:
NCH, 4, number of requesting channels (2..16)
CH_W, 2, channel index width = clog2(NCH)
OVERLAP, 1, 1 = overlapping detection (after a match, next state is S1); 0 = non-overlapping (next state is S0)
CNT_W, 8, per-channel match counter width (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  NCH  channel i has a bit pending
in_bit  in  NCH  serial bit of channel i
in_ready  out  NCH  one-hot grant (combinational); channel i's bit is consumed when in_valid[i] & in_ready[i] at a clk edge
chan_clr  in  NCH  synchronous per-channel clear
z_valid  out  1  registered match pulse
z_ch  out  CH_W  channel index of the match; held between pulses
cnt_sel  in  CH_W  counter readout select
cnt_rdata  out  CNT_W  match count of channel cnt_sel (combinational read)

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high. On reset, every channel state goes to S0, rr_ptr=0, z_valid=0, z_ch=0 and all counters are 0.
- Per-channel states (2-bit encoding): S0 = idle, S1 = seen "1", S2 = seen "10", S3 = seen "101".
- State transitions:
  - S0: x=1 -> S1; x=0 -> S0.
  - S1: x=1 -> S1; x=0 -> S2.
  - S2: x=1 -> S3; x=0 -> S0.
  - S3: x=1 -> match=1, next state is S1 if OVERLAP else S0; x=0 -> S2.
- Arbitration:
  - eligible = in_valid & ~chan_clr.
  - Grant goes to the first eligible channel scanning rr_ptr, rr_ptr+1, ... modulo NCH.
  - in_ready is all-zero when no channel is eligible.
  - in_ready is never multi-hot.
- Pointer update: after a grant to channel g, rr_ptr <= (g+1) mod NCH. The pointer is unchanged when there is no grant.
- Step: on the granted edge only the granted channel's state is updated. Non-granted channels hold their state regardless of in_bit.
- Match output:
  - Latency is 1 cycle: z_valid <= match of the granted step. When z_valid is set, z_ch <= g.
  - z_valid is 0 in any cycle with no grant or no match.
  - Sustained throughput is 1 bit per cycle in aggregate.
- chan_clr:
  - Masks the channel out of arbitration for that cycle.
  - Forces its state to S0 and its counter to 0 at the edge.
  - A z_valid already registered is not retracted.
- Reset mid-stream: partial sequences are discarded, and no z_valid appears in the cycle after reset is asserted.
- Fairness: with all NCH channels continuously valid, each channel is granted exactly once every NCH cycles.

Optional Feature:
SEQ_SCHED_CNT_EN
- Defined: a CNT_W-bit match counter per channel, incremented on each match of that channel and saturating at all-ones. Cleared by reset or chan_clr. cnt_rdata = cnt[cnt_sel].
- Undefined: no counters are built and cnt_rdata is tied to 0. Ports are unchanged.

Decomposition:
- Shared package seq_sched_pkg: state localparams S_IDLE=2'd0, S_1=2'd1, S_10=2'd2, S_101=2'd3 and the state width constant ST_W=2. The existing detectors and their benches reuse the same encoding.
- One sub-module, seq1011_step: purely combinational (state, x, OVERLAP) -> (next_state, match). It is instantiated once and fed from the state-file mux. The arbiter stays in the top module.

Test Plan:
- Single channel ch1 fed 1,0,1,1,0,1,1 (others idle), OVERLAP=1 -> z_valid pulses on the cycles after the 4th and 7th bits, z_ch=1 both times; count=2.
- Same stream with OVERLAP=0 -> a single pulse after the 4th bit only.
- All 4 channels continuously valid, ch0 and ch2 carrying 1011 and ch1/ch3 carrying zeros -> grants cycle 0,1,2,3,0,...; after 16 cycles z_valid pulses with z_ch=0 then z_ch=2, no others.
- ch3 mid-sequence (state S3), chan_clr[3]=1 for one cycle with in_valid[3]=1 -> in_ready[3]=0 that cycle; next bit 1 gives no match; state is S1.
- Reset asserted while ch0 is in S3 and its next bit is 1 -> no z_valid; after release, 1011 on ch0 is needed to produce z_valid with z_ch=0.
- With SEQ_SCHED_CNT_EN and CNT_W=2, five matches on ch2 -> cnt_sel=2 reads 3 (saturated); without the macro it reads 0.
